hazard_pipeline_sink: RTL and testbench

- Consumer end of the load-use stall interface. Owns the PC register, the IF/ID pipeline register and ID/EX control-bubble insertion.
- Acts on pc_write_en / ifid_write_en / stall_flush from the stall control unit, and on branch_taken from EX.
- Also tracks stall state, keeps saturating stall/flush performance counters, and flags protocol violations on the stall interface.

---
 rtl/hazard_pipeline_sink.sv | 123 ++++++++++++
 tb/tb_hazard_pipeline_sink.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_pipeline_sink.sv
// Consumer side of the load-use stall interface: PC, IF/ID register, ID/EX bubble
// insertion, stall FSM, saturating perf counters and a sticky protocol-error flag.
module hazard_pipeline_sink #(
  parameter int unsigned          ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
  parameter int unsigned          CTRL_W    = 10,
  parameter int unsigned          CNT_W     = 16,
  parameter int unsigned          MAX_STALL = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_write_en,
  input  logic              ifid_write_en,
  input  logic              stall_flush,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [ADDR_W-1:0] imem_instr,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc_plus4,
  output logic              ifid_valid,
  output logic [CTRL_W-1:0] idex_ctrl,
  output logic              idex_valid,
  output logic              stalled,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count,
  output logic              proto_err
);

  localparam int unsigned RUN_W = $clog2(MAX_STALL + 1);

  typedef enum logic {RUN, STALL} state_t;

  state_t            state, state_next;
  logic [RUN_W-1:0]  run_len, run_next;
  logic              eff_stall;
  logic              enc_err;
  logic              wd_trip;
  logic [ADDR_W-1:0] pc_plus4;

  assign eff_stall = stall_flush & ~branch_taken;
  assign pc_plus4  = pc + ADDR_W'(4);

  // Datapath registers: a branch redirect overrides every stall-control input.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_PC;
      ifid_instr    <= '0;
      ifid_pc_plus4 <= '0;
      ifid_valid    <= 1'b0;
      idex_ctrl     <= '0;
      idex_valid    <= 1'b0;
    end else begin
      if (branch_taken)     pc <= branch_target;
      else if (pc_write_en) pc <= pc_plus4;

      if (branch_taken) begin
        ifid_instr <= '0;
        ifid_valid <= 1'b0;
      end else if (ifid_write_en) begin
        ifid_instr    <= imem_instr;
        ifid_pc_plus4 <= pc_plus4;
        ifid_valid    <= 1'b1;
      end

      if (stall_flush || branch_taken) begin
        idex_ctrl  <= '0;
        idex_valid <= 1'b0;
      end else begin
        idex_ctrl  <= id_ctrl;
        idex_valid <= ifid_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      run_len <= '0;
    end else begin
      state   <= state_next;
      run_len <= run_next;
    end
  end

  always_comb begin
    state_next = state;
    run_next   = run_len;
    if (eff_stall) begin
      state_next = STALL;
      if (state == RUN)
        run_next = RUN_W'(1);
      else if (run_len < RUN_W'(MAX_STALL))
        run_next = run_len + RUN_W'(1);
    end else begin
      state_next = RUN;
      run_next   = '0;
    end
  end

  always_comb begin
    stalled = (state == STALL);
    enc_err = (pc_write_en != ifid_write_en) || (stall_flush == pc_write_en);
    wd_trip = eff_stall && (run_next == RUN_W'(MAX_STALL));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
      proto_err   <= 1'b0;
    end else begin
      if (eff_stall && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
      if (branch_taken && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
      if (enc_err || wd_trip)
        proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_pipeline_sink.sv
// Self-checking bench for hazard_pipeline_sink: a vector table through a scoreboard
// queue, plus hand sequences for PC wrap and counter saturation on a second instance.
module tb_hazard_pipeline_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_write_en, ifid_write_en, stall_flush, branch_taken;
  logic [31:0] branch_target, imem_instr;
  logic [9:0]  id_ctrl;

  logic [31:0] pc, ifid_instr, ifid_pc_plus4;
  logic        ifid_valid, idex_valid, stalled, proto_err;
  logic [9:0]  idex_ctrl;
  logic [15:0] stall_count, flush_count;

  logic [31:0] a_pc, a_ifid_instr, a_ifid_pc_plus4;
  logic        a_ifid_valid, a_idex_valid, a_stalled, a_proto_err;
  logic [9:0]  a_idex_ctrl;
  logic [2:0]  a_stall_count, a_flush_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_pipeline_sink u_main (
    .clk(clk), .reset(reset), .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en),
    .stall_flush(stall_flush), .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_instr(imem_instr), .id_ctrl(id_ctrl), .pc(pc), .ifid_instr(ifid_instr),
    .ifid_pc_plus4(ifid_pc_plus4), .ifid_valid(ifid_valid), .idex_ctrl(idex_ctrl),
    .idex_valid(idex_valid), .stalled(stalled), .stall_count(stall_count),
    .flush_count(flush_count), .proto_err(proto_err)
  );

  hazard_pipeline_sink #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(3)) u_alt (
    .clk(clk), .reset(reset), .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en),
    .stall_flush(stall_flush), .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_instr(imem_instr), .id_ctrl(id_ctrl), .pc(a_pc), .ifid_instr(a_ifid_instr),
    .ifid_pc_plus4(a_ifid_pc_plus4), .ifid_valid(a_ifid_valid), .idex_ctrl(a_idex_ctrl),
    .idex_valid(a_idex_valid), .stalled(a_stalled), .stall_count(a_stall_count),
    .flush_count(a_flush_count), .proto_err(a_proto_err)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        iv;
    logic [9:0]  ctrl;
    logic        xv;
    logic        st;
    logic [15:0] sc;
    logic [15:0] fc;
    logic        pe;
  } exp_t;

  typedef struct packed {
    logic        rst;
    logic        pwe;
    logic        iwe;
    logic        fl;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] instr;
    logic [9:0]  ctrl;
    exp_t        e;
  } vec_t;

  vec_t        tbl [19];
  exp_t        sbq [$];
  logic [31:0] alt_q [$];

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic pwe, input logic iwe, input logic fl,
                       input logic br, input logic [31:0] tgt, input logic [31:0] ins,
                       input logic [9:0] ctl);
    reset         = rst;
    pc_write_en   = pwe;
    ifid_write_en = iwe;
    stall_flush   = fl;
    branch_taken  = br;
    branch_target = tgt;
    imem_instr    = ins;
    id_ctrl       = ctl;
  endtask

  initial begin
    exp_t e;
    tbl[0]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,32'h0,10'h0,
                '{32'h0,32'h0,32'h0,1'b0,10'h0,1'b0,1'b0,16'd0,16'd0,1'b0}};
    tbl[1]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,32'h8C01_0000,10'h001,
                '{32'h4,32'h8C01_0000,32'h4,1'b1,10'h001,1'b0,1'b0,16'd0,16'd0,1'b0}};
    tbl[2]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,32'h8C02_0004,10'h002,
                '{32'h8,32'h8C02_0004,32'h8,1'b1,10'h002,1'b1,1'b0,16'd0,16'd0,1'b0}};
    tbl[3]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,32'hDEAD_0000,10'h003,
                '{32'h8,32'h8C02_0004,32'h8,1'b1,10'h000,1'b0,1'b1,16'd1,16'd0,1'b0}};
    tbl[4]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,32'h0043_0820,10'h004,
                '{32'hC,32'h0043_0820,32'hC,1'b1,10'h004,1'b1,1'b0,16'd1,16'd0,1'b0}};
    tbl[5]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,32'h40,32'hDEAD_0001,10'h005,
                '{32'h40,32'h0,32'hC,1'b0,10'h000,1'b0,1'b0,16'd1,16'd1,1'b0}};
    tbl[6]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,32'h1111_1111,10'h006,
                '{32'h44,32'h1111_1111,32'h44,1'b1,10'h006,1'b0,1'b0,16'd1,16'd1,1'b0}};
    tbl[7]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,32'h2222_2222,10'h007,
                '{32'h48,32'h2222_2222,32'h48,1'b1,10'h007,1'b1,1'b0,16'd1,16'd1,1'b0}};
    tbl[8]  = '{1'b0,1'b1,1'b1,1'b0,1'b1,32'h100,32'hDEAD_0002,10'h008,
                '{32'h100,32'h0,32'h48,1'b0,10'h000,1'b0,1'b0,16'd1,16'd2,1'b0}};
    tbl[9]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,32'hDEAD_0003,10'h009,
                '{32'h100,32'h0,32'h48,1'b0,10'h000,1'b0,1'b1,16'd2,16'd2,1'b0}};
    tbl[10] = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,32'hDEAD_0003,10'h009,
                '{32'h100,32'h0,32'h48,1'b0,10'h000,1'b0,1'b1,16'd3,16'd2,1'b0}};
    tbl[11] = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,32'hDEAD_0003,10'h009,
                '{32'h100,32'h0,32'h48,1'b0,10'h000,1'b0,1'b1,16'd4,16'd2,1'b0}};
    tbl[12] = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,32'hDEAD_0003,10'h009,
                '{32'h100,32'h0,32'h48,1'b0,10'h000,1'b0,1'b1,16'd5,16'd2,1'b1}};
    tbl[13] = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,32'h3333_3333,10'h00A,
                '{32'h104,32'h3333_3333,32'h104,1'b1,10'h00A,1'b0,1'b0,16'd5,16'd2,1'b1}};
    tbl[14] = '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,32'h0,10'h0,
                '{32'h0,32'h0,32'h0,1'b0,10'h0,1'b0,1'b0,16'd0,16'd0,1'b0}};
    tbl[15] = '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,32'h4444_4444,10'h00B,
                '{32'h4,32'h0,32'h0,1'b0,10'h00B,1'b0,1'b0,16'd0,16'd0,1'b1}};
    tbl[16] = '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,32'h0,10'h0,
                '{32'h0,32'h0,32'h0,1'b0,10'h0,1'b0,1'b0,16'd0,16'd0,1'b0}};
    tbl[17] = '{1'b0,1'b1,1'b1,1'b1,1'b0,32'h0,32'h5555_5555,10'h00C,
                '{32'h4,32'h5555_5555,32'h4,1'b1,10'h000,1'b0,1'b1,16'd1,16'd0,1'b1}};
    tbl[18] = '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,32'h0,10'h0,
                '{32'h0,32'h0,32'h0,1'b0,10'h0,1'b0,1'b0,16'd0,16'd0,1'b0}};

    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0);
    @(posedge clk); #1;

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].rst, tbl[i].pwe, tbl[i].iwe, tbl[i].fl, tbl[i].br,
            tbl[i].tgt, tbl[i].instr, tbl[i].ctrl);
      sbq.push_back(tbl[i].e);
      @(posedge clk); #1;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL scoreboard [%0d]: queue empty, expected one entry", i);
      end else begin
        e = sbq.pop_front();
        chk("pc",            i, pc,                    e.pc);
        chk("ifid_instr",    i, ifid_instr,            e.instr);
        chk("ifid_pc_plus4", i, ifid_pc_plus4,         e.pc4);
        chk("ifid_valid",    i, {31'b0, ifid_valid},   {31'b0, e.iv});
        chk("idex_ctrl",     i, {22'b0, idex_ctrl},    {22'b0, e.ctrl});
        chk("idex_valid",    i, {31'b0, idex_valid},   {31'b0, e.xv});
        chk("stalled",       i, {31'b0, stalled},      {31'b0, e.st});
        chk("stall_count",   i, {16'b0, stall_count},  {16'b0, e.sc});
        chk("flush_count",   i, {16'b0, flush_count},  {16'b0, e.fc});
        chk("proto_err",     i, {31'b0, proto_err},    {31'b0, e.pe});
      end
    end

    // PC wrap on the instance reset to 0xFFFFFFF8.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0);
    alt_q.push_back(32'hFFFF_FFF8);
    @(posedge clk); #1;
    chk("wrap_reset_pc", 0, a_pc, alt_q.pop_front());
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, 32'h0000_0013, '0);
      alt_q.push_back(32'hFFFF_FFF8 + 32'(4 * i));
      @(posedge clk); #1;
      chk("wrap_pc", i, a_pc, alt_q.pop_front());
    end

    // 3-bit stall counter saturates at 7.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0);
    @(posedge clk); #1;
    for (int i = 1; i <= 9; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, '0);
      alt_q.push_back((i < 7) ? 32'(i) : 32'd7);
      @(posedge clk); #1;
      chk("sat_stall_count", i, {29'b0, a_stall_count}, alt_q.pop_front());
    end
    chk("sat_proto_err", 0, {31'b0, a_proto_err}, 32'd1);

    // 3-bit flush counter saturates at 7.
    for (int i = 1; i <= 9; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h200, '0, '0);
      alt_q.push_back((i < 7) ? 32'(i) : 32'd7);
      @(posedge clk); #1;
      chk("sat_flush_count", i, {29'b0, a_flush_count}, alt_q.pop_front());
    end
    chk("sat_stall_hold", 0, {29'b0, a_stall_count}, 32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
